// File: rtl/aoi22_bus_arbiter_if.sv
// Bus bundle between the two requesters and the AOI22 column arbiter.
interface aoi22_bus_arbiter_if #(parameter int DATA_W = 8);
  logic              req0, req1;
  logic [DATA_W-1:0] d0, d1;
  logic              gnt0, gnt1;
  logic [DATA_W-1:0] sel_a, sel_b, zn, q;
  logic              q_vld;

  modport master (output req0, req1, d0, d1,
                  input  gnt0, gnt1, sel_a, sel_b, zn, q, q_vld);
  modport slave  (input  req0, req1, d0, d1,
                  output gnt0, gnt1, sel_a, sel_b, zn, q, q_vld);
endinterface

// File: rtl/aoi22_bus_arbiter.sv
// Round-robin two-requester arbiter driving the select lines of an AOI22 bus
// column, with guaranteed dead cycles between owners and a registered bus copy.
module aoi22_bus_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input logic               CK,
  input logic               RN,
  aoi22_bus_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int TW = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam bit PREEMPT = (MAX_HOLD != 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] q_q;
  logic              q_vld_q;

  logic gnt0, gnt1, pick_v, pick_id, own_req, oth_req;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Tie goes to whoever did not own the bus last.
  always_comb begin
    pick_v  = bus.req0 | bus.req1;
    pick_id = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  end

  assign own_req = gnt1 ? bus.req1 : bus.req0;
  assign oth_req = gnt1 ? bus.req0 : bus.req1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (pick_v) state_d = pick_id ? GNT1 : GNT0;
      end
      GNT0, GNT1: begin
        if (!own_req || (PREEMPT && oth_req && hold_q == HOLD_LAST)) begin
          state_d = TURN;
          last_d  = gnt1;
          hold_d  = '0;
          turn_d  = '0;
        end else if (!oth_req) begin
          // Only contended cycles count; a lone requester keeps the bus.
          hold_d = '0;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d  = '0;
          state_d = pick_v ? (pick_id ? GNT1 : GNT0) : IDLE;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      hold_q  <= '0;
      turn_q  <= '0;
      last_q  <= 1'b1;
      q_q     <= '0;
      q_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      last_q  <= last_d;
      q_q     <= ~bus.zn;
      q_vld_q <= gnt0 | gnt1;
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.sel_a = {DATA_W{gnt0}};
  assign bus.sel_b = {DATA_W{gnt1}};
  assign bus.zn    = ~((bus.d0 & bus.sel_a) | (bus.d1 & bus.sel_b));
  assign bus.q     = q_q;
  assign bus.q_vld = q_vld_q;
endmodule

// File: tb/tb_aoi22_bus_arbiter.sv
// Directed vector table plus corner sequences on one arbiter (MAX_HOLD=4,
// TURN_CYC=1), and a long random run with property checks on a TURN_CYC=3 copy.
module tb_aoi22_bus_arbiter;
  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  aoi22_bus_arbiter_if #(.DATA_W(8)) ba ();
  aoi22_bus_arbiter_if #(.DATA_W(8)) bb ();

  aoi22_bus_arbiter #(.DATA_W(8), .MAX_HOLD(4), .TURN_CYC(1)) dut_a (.CK(CK), .RN(RN), .bus(ba));
  aoi22_bus_arbiter #(.DATA_W(8), .MAX_HOLD(4), .TURN_CYC(3)) dut_b (.CK(CK), .RN(RN), .bus(bb));

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CK);
    RN = 1'b0;
    @(negedge CK);
    RN = 1'b1;
  endtask

  typedef struct {
    logic rn, r0, r1;
    logic g0, g1;
    logic [7:0] zn, q;
    logic qv;
  } vec_t;

  vec_t tv[16];

  initial begin
    ba.req0 = 0; ba.req1 = 0; ba.d0 = 8'hA5; ba.d1 = 8'h3C;
    bb.req0 = 0; bb.req1 = 0; bb.d0 = 8'h00; bb.d1 = 8'h00;

    //         rn r0 r1  g0 g1  zn     q      qv
    tv[0]  = '{0, 0, 0,  0, 0,  8'hFF, 8'h00, 0};
    tv[1]  = '{1, 1, 0,  1, 0,  8'h5A, 8'h00, 0};
    tv[2]  = '{1, 1, 0,  1, 0,  8'h5A, 8'hA5, 1};
    tv[3]  = '{1, 1, 1,  1, 0,  8'h5A, 8'hA5, 1};
    tv[4]  = '{1, 0, 0,  0, 0,  8'hFF, 8'hA5, 1};
    tv[5]  = '{1, 0, 0,  0, 0,  8'hFF, 8'h00, 0};
    tv[6]  = '{0, 0, 0,  0, 0,  8'hFF, 8'h00, 0};
    tv[7]  = '{1, 1, 1,  1, 0,  8'h5A, 8'h00, 0};
    tv[8]  = '{1, 0, 1,  0, 0,  8'hFF, 8'hA5, 1};
    tv[9]  = '{1, 0, 1,  0, 1,  8'hC3, 8'h00, 0};
    tv[10] = '{1, 0, 1,  0, 1,  8'hC3, 8'h3C, 1};
    tv[11] = '{1, 0, 0,  0, 0,  8'hFF, 8'h3C, 1};
    tv[12] = '{1, 1, 0,  1, 0,  8'h5A, 8'h00, 0};
    tv[13] = '{1, 0, 1,  0, 0,  8'hFF, 8'hA5, 1};
    tv[14] = '{1, 0, 0,  0, 0,  8'hFF, 8'h00, 0};
    tv[15] = '{1, 0, 0,  0, 0,  8'hFF, 8'h00, 0};

    for (int i = 0; i < 16; i++) begin
      RN = tv[i].rn; ba.req0 = tv[i].r0; ba.req1 = tv[i].r1;
      @(posedge CK); #1;
      chk1($sformatf("v%0d_gnt0", i), ba.gnt0, tv[i].g0);
      chk1($sformatf("v%0d_gnt1", i), ba.gnt1, tv[i].g1);
      chk8($sformatf("v%0d_zn", i), ba.zn, tv[i].zn);
      chk8($sformatf("v%0d_q", i), ba.q, tv[i].q);
      chk1($sformatf("v%0d_qvld", i), ba.q_vld, tv[i].qv);
      @(negedge CK);
    end

    // Both requesting continuously: 4-cycle grants alternating with one dead cycle.
    ba.req0 = 0; ba.req1 = 0;
    do_reset();
    ba.req0 = 1; ba.req1 = 1;
    begin
      logic pe0, pe1, e0, e1;
      pe0 = 0; pe1 = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge CK); #1;
        e0 = (k % 10) < 4;
        e1 = (k % 10) >= 5 && (k % 10) < 9;
        chk1($sformatf("rr%0d_gnt0", k), ba.gnt0, e0);
        chk1($sformatf("rr%0d_gnt1", k), ba.gnt1, e1);
        chk8($sformatf("rr%0d_q", k), ba.q, pe0 ? 8'hA5 : (pe1 ? 8'h3C : 8'h00));
        pe0 = e0; pe1 = e1;
      end
    end

    // Lone requester is never preempted; contention starts the hold limit.
    ba.req0 = 0; ba.req1 = 0;
    do_reset();
    ba.req1 = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge CK); #1;
      chk1($sformatf("solo%0d_gnt1", k), ba.gnt1, 1'b1);
      chk1($sformatf("solo%0d_gnt0", k), ba.gnt0, 1'b0);
    end
    @(negedge CK);
    ba.req0 = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CK); #1;
      chk1($sformatf("pre%0d_gnt1", k), ba.gnt1, k <= 3);
      chk1($sformatf("pre%0d_gnt0", k), ba.gnt0, k == 5);
    end

    // Asynchronous reset in the middle of a grant.
    ba.req0 = 0; ba.req1 = 0;
    do_reset();
    ba.req1 = 1;
    @(posedge CK); #1;
    chk1("ar_gnt1_on", ba.gnt1, 1'b1);
    @(posedge CK); #1;
    chk8("ar_q_on", ba.q, 8'h3C);
    chk1("ar_qvld_on", ba.q_vld, 1'b1);
    #2 RN = 1'b0;
    #1;
    chk1("ar_gnt1_off", ba.gnt1, 1'b0);
    chk1("ar_qvld_off", ba.q_vld, 1'b0);
    chk8("ar_q_off", ba.q, 8'h00);
    chk8("ar_zn_off", ba.zn, 8'hFF);
    @(negedge CK);
    RN = 1'b1; ba.req0 = 1; ba.req1 = 1;
    @(posedge CK); #1;
    chk1("ar_after_gnt0", ba.gnt0, 1'b1);
    chk1("ar_after_gnt1", ba.gnt1, 1'b0);
    ba.req0 = 0; ba.req1 = 0;

    // Random traffic on the TURN_CYC=3 instance with property checks.
    do_reset();
    begin
      logic r0, r1, pr0, pr1, g0, g1, pg0, pg1;
      logic [7:0] exp_q, wz;
      int dead;
      bit owned;
      r0 = 0; r1 = 0; pr0 = 0; pr1 = 0; pg0 = 0; pg1 = 0;
      exp_q = 8'h00; dead = 0; owned = 0;
      for (int c = 0; c < 10000; c++) begin
        @(negedge CK);
        g0 = bb.gnt0; g1 = bb.gnt1;
        chk1("rnd_excl", g0 & g1, 1'b0);
        chk8("rnd_sel_excl", bb.sel_a & bb.sel_b, 8'h00);
        chk8("rnd_q", bb.q, exp_q);
        chk1("rnd_qvld", bb.q_vld, pg0 | pg1);
        if (g0) chk1("rnd_gnt0_req", pr0, 1'b1);
        if (g1) chk1("rnd_gnt1_req", pr1, 1'b1);
        if (owned && !(pg0 | pg1) && dead == 3 && (pr0 | pr1))
          chk1("rnd_gap_exact", g0 | g1, 1'b1);
        if (g0 | g1) begin
          if (owned && !(pg0 | pg1)) chk1("rnd_gap_min", dead >= 3, 1'b1);
          dead = 0; owned = 1;
        end else begin
          dead++;
        end
        if ($urandom_range(7) == 0) r0 = ~r0;
        if ($urandom_range(7) == 0) r1 = ~r1;
        bb.req0 = r0; bb.req1 = r1;
        bb.d0 = 8'($urandom); bb.d1 = 8'($urandom);
        #1;
        wz = ~((bb.d0 & {8{g0}}) | (bb.d1 & {8{g1}}));
        chk8("rnd_zn", bb.zn, wz);
        exp_q = ~wz;
        pr0 = r0; pr1 = r1; pg0 = g0; pg1 = g1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
